// File: rtl/SB_IO.sv
// Behavioural stand-in for the iCE40 SB_IO primitive, covering only the
// output-register path used by the HUB75 pin stages.
module SB_IO #(
  parameter logic [5:0] PIN_TYPE = 6'b010100
) (
  output logic PACKAGE_PIN,
  input  logic OUTPUT_CLK,
  input  logic D_OUT_0
);

  generate
    if (PIN_TYPE[5:2] == 4'b0101) begin : g_registered
      always_ff @(posedge OUTPUT_CLK) begin
        PACKAGE_PIN <= D_OUT_0;
      end
    end else begin : g_direct
      assign PACKAGE_PIN = D_OUT_0;
    end
  endgenerate

endmodule

// File: rtl/hub75_blanking.sv
// HUB75 output-enable stage: lights the panel for plane_weight LSB units,
// with a live brightness limit inside each unit, through a registered IOB.
module hub75_blanking #(
  parameter int N_PLANES = 8
) (
  input  logic                clk,
  input  logic                rst,
  output logic                hub75_blank,
  input  logic [N_PLANES-1:0] blank_plane,
  input  logic                blank_go,
  output logic                blank_rdy,
  input  logic [7:0]          cfg_bcm_bit_len,
  input  logic [7:0]          cfg_brightness
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ON   = 1'b1
  } state_t;

  localparam logic [N_PLANES-1:0] WEIGHT_ONE = N_PLANES'(1);

  state_t              state;
  logic [N_PLANES-1:0] weight;
  logic [7:0]          unit_len;
  logic [7:0]          unit_cnt;
  logic                on;
  logic                iob_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      blank_rdy <= 1'b1;
      weight    <= '0;
      unit_len  <= '0;
      unit_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (blank_go && (blank_plane != '0)) begin
            state     <= ST_ON;
            blank_rdy <= 1'b0;
            weight    <= blank_plane;
            unit_len  <= cfg_bcm_bit_len;
            unit_cnt  <= '0;
          end
        end
        ST_ON: begin
          // Weight counts down once per completed LSB unit; the last unit ends the period.
          if (unit_cnt == unit_len) begin
            unit_cnt <= '0;
            weight   <= weight - WEIGHT_ONE;
            if (weight == WEIGHT_ONE) begin
              state     <= ST_IDLE;
              blank_rdy <= 1'b1;
            end
          end else begin
            unit_cnt <= unit_cnt + 8'd1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          blank_rdy <= 1'b1;
        end
      endcase
    end
  end

  assign on    = (state == ST_ON) && (unit_cnt < cfg_brightness);
  // Forcing D high during reset blanks the pin from the first edge despite the IOB having no reset.
  assign iob_d = rst | ~on;

  SB_IO #(
    .PIN_TYPE(6'b010100)
  ) u_blank_iob (
    .PACKAGE_PIN(hub75_blank),
    .OUTPUT_CLK (clk),
    .D_OUT_0    (iob_d)
  );

endmodule

// File: tb/tb_hub75_blanking.sv
// Bench for hub75_blanking: directed windows with literal expectations plus a
// randomized stream checked every cycle against a period/elapsed-time model.
module tb_hub75_blanking;

  logic       clk;
  logic       rst;
  logic       hub75_blank;
  logic [7:0] blank_plane;
  logic       blank_go;
  logic       blank_rdy;
  logic [7:0] cfg_bcm_bit_len;
  logic [7:0] cfg_brightness;

  int n_checks;
  int n_fail;

  hub75_blanking #(.N_PLANES(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .hub75_blank    (hub75_blank),
    .blank_plane    (blank_plane),
    .blank_go       (blank_go),
    .blank_rdy      (blank_rdy),
    .cfg_bcm_bit_len(cfg_bcm_bit_len),
    .cfg_brightness (cfg_brightness)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a request of weight W with unit length L keeps the panel
  // busy for W*(L+1) cycles; within each unit the first 'brightness' cycles are lit.
  bit m_busy;
  int m_elapsed;
  int m_dur;
  int m_len;
  bit exp_pin;
  bit exp_rdy;

  initial begin
    bit on_now;
    m_busy  = 1'b0;
    m_elapsed = 0;
    m_dur   = 0;
    m_len   = 0;
    exp_pin = 1'b1;
    exp_rdy = 1'b1;
    @(posedge clk);
    forever begin
      @(negedge clk);
      check_output("model_blank_pin", int'(hub75_blank), int'(exp_pin));
      check_output("model_blank_rdy", int'(blank_rdy), int'(exp_rdy));
      on_now = m_busy && (((m_elapsed - 1) % (m_len + 1)) < int'(cfg_brightness));
      if (rst) begin
        m_busy  = 1'b0;
        exp_pin = 1'b1;
        exp_rdy = 1'b1;
      end else begin
        exp_pin = !on_now;
        if (m_busy) begin
          if (m_elapsed == m_dur) m_busy = 1'b0;
          else m_elapsed++;
        end else if (blank_go && (blank_plane != 8'd0)) begin
          m_busy    = 1'b1;
          m_elapsed = 1;
          m_len     = int'(cfg_bcm_bit_len);
          m_dur     = int'(blank_plane) * (m_len + 1);
        end
        exp_rdy = !m_busy;
      end
    end
  end

  task automatic apply_stimulus(input logic [7:0] plane);
    blank_plane = plane;
    blank_go    = 1'b1;
    @(posedge clk);
    #1;
    blank_go    = 1'b0;
  endtask

  // Offset k of the window is cycle T+k, where T is the cycle the request was presented.
  task automatic run_window(input int n, input int go_at, input logic [7:0] go_plane,
                            input int len_at, input logic [7:0] new_len, input int rst_at,
                            output int lows, output int first_low, output int rdy_at,
                            output logic [7:0] pat);
    lows = 0;
    first_low = 0;
    rdy_at = 0;
    pat = 8'h00;
    for (int k = 1; k <= n; k++) begin
      blank_go = (k == go_at);
      if (k == go_at) blank_plane = go_plane;
      if (k == len_at) cfg_bcm_bit_len = new_len;
      rst = (k == rst_at);
      @(negedge clk);
      if (!hub75_blank) begin
        lows++;
        if (first_low == 0) first_low = k;
      end
      if (blank_rdy && rdy_at == 0) rdy_at = k;
      if (k >= 2 && k <= 9) pat[k-2] = hub75_blank;
      @(posedge clk);
      #1;
    end
    blank_go = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    int lows, first_low, rdy_at;
    logic [7:0] pat;
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    blank_go = 1'b0;
    blank_plane = 8'h00;
    cfg_bcm_bit_len = 8'd3;
    cfg_brightness = 8'd255;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("reset_pin", int'(hub75_blank), 1);
    check_output("reset_rdy", int'(blank_rdy), 1);
    @(posedge clk);
    #1;

    apply_stimulus(8'h04);
    run_window(20, 0, 8'h00, 0, 8'h00, 0, lows, first_low, rdy_at, pat);
    check_output("basic_lows", lows, 16);
    check_output("basic_first_low", first_low, 2);
    check_output("basic_rdy_at", rdy_at, 17);

    cfg_brightness = 8'd2;
    apply_stimulus(8'h02);
    run_window(12, 0, 8'h00, 0, 8'h00, 0, lows, first_low, rdy_at, pat);
    check_output("bright2_lows", lows, 4);
    check_output("bright2_pattern", int'(pat), 8'hCC);
    check_output("bright2_rdy_at", rdy_at, 9);

    cfg_brightness = 8'd0;
    apply_stimulus(8'h02);
    run_window(12, 0, 8'h00, 0, 8'h00, 0, lows, first_low, rdy_at, pat);
    check_output("bright0_lows", lows, 0);
    check_output("bright0_rdy_at", rdy_at, 9);
    cfg_brightness = 8'd255;

    apply_stimulus(8'h00);
    run_window(6, 0, 8'h00, 0, 8'h00, 0, lows, first_low, rdy_at, pat);
    check_output("zero_plane_lows", lows, 0);
    check_output("zero_plane_rdy_at", rdy_at, 1);

    apply_stimulus(8'h04);
    run_window(22, 5, 8'h80, 0, 8'h00, 0, lows, first_low, rdy_at, pat);
    check_output("second_go_lows", lows, 16);
    check_output("second_go_rdy_at", rdy_at, 17);

    apply_stimulus(8'h04);
    run_window(22, 16, 8'h01, 0, 8'h00, 0, lows, first_low, rdy_at, pat);
    check_output("final_go_lows", lows, 16);
    check_output("final_go_rdy_at", rdy_at, 17);

    apply_stimulus(8'h04);
    run_window(22, 0, 8'h00, 5, 8'd7, 0, lows, first_low, rdy_at, pat);
    check_output("len_change_lows", lows, 16);
    check_output("len_change_rdy_at", rdy_at, 17);
    cfg_bcm_bit_len = 8'd3;

    apply_stimulus(8'h04);
    run_window(12, 0, 8'h00, 0, 8'h00, 5, lows, first_low, rdy_at, pat);
    check_output("rst_mid_lows", lows, 4);
    check_output("rst_mid_rdy_at", rdy_at, 6);

    cfg_bcm_bit_len = 8'd0;
    for (int p = 0; p < 8; p++) begin
      apply_stimulus(8'(1 << p));
      run_window((1 << p) + 4, 0, 8'h00, 0, 8'h00, 0, lows, first_low, rdy_at, pat);
      check_output($sformatf("sweep_lows_p%0d", p), lows, 1 << p);
      check_output($sformatf("sweep_rdy_at_p%0d", p), rdy_at, (1 << p) + 1);
    end

    // Random stream: the model process checks every cycle.
    for (int c = 0; c < 6000; c++) begin
      int r;
      blank_go = ($urandom % 4) == 0;
      r = $urandom % 8;
      if (r == 0) blank_plane = 8'h00;
      else if (r <= 5) blank_plane = 8'(1 << $urandom_range(0, 5));
      else blank_plane = 8'($urandom_range(1, 15));
      if (($urandom % 16) == 0) cfg_bcm_bit_len = 8'($urandom_range(0, 7));
      if (($urandom % 8) == 0) cfg_brightness = 8'($urandom_range(0, 9));
      rst = ($urandom % 300) == 0;
      @(posedge clk);
      #1;
    end
    blank_go = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
